idiv_seq: RTL

IDIV_SEQ -- requirements
Module: idiv_seq

---
 rtl/ej32_pkg.sv | 20 ++
 rtl/div_int.sv | 50 +++++
 rtl/idiv_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ej32_pkg.sv
// Shared widths, operation encoding and controller states for the signed
// sequential integer divider.
package ej32_pkg;

  localparam int DSZ_DEFAULT = 32;
  localparam int DSZ_MSB     = DSZ_DEFAULT - 1;

  typedef enum logic {
    DIV_Q = 1'b0,
    DIV_R = 1'b1
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_int.sv
// Unsigned restoring divider, one quotient bit per clock. Asserting rst loads
// the operands and starts a new DSZ-step division.
module div_int #(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DSZ-1:0] dividend,
  input  logic [DSZ-1:0] divisor,
  output logic [DSZ-1:0] quotient,
  output logic [DSZ-1:0] remainder,
  output logic           busy,
  output logic           zero
);

  localparam int CW = $clog2(DSZ + 1);

  logic [CW-1:0]  count;
  logic [DSZ-1:0] dvs;
  logic [DSZ:0]   trial;
  logic [DSZ:0]   diff;

  // remainder < divisor always holds, so diff[DSZ] is a clean borrow flag
  always_comb begin
    trial = {remainder, quotient[DSZ-1]};
    diff  = trial - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
      count     <= CW'(DSZ);
      zero      <= (divisor == '0);
    end else if (count != '0) begin
      if (!diff[DSZ]) begin
        remainder <= diff[DSZ-1:0];
        quotient  <= {quotient[DSZ-2:0], 1'b1};
      end else begin
        remainder <= trial[DSZ-1:0];
        quotient  <= {quotient[DSZ-2:0], 1'b0};
      end
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/idiv_seq.sv
// Signed sequential divider: converts operands to magnitudes, runs the
// unsigned iterative core and applies truncating-division sign correction.
module idiv_seq
  import ej32_pkg::*;
#(
  parameter int DSZ = DSZ_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [DSZ-1:0] a,
  input  logic [DSZ-1:0] b,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [DSZ-1:0] result,
  output logic           dz
);

  div_state_e     state;
  div_op_e        op_q;
  logic           sign_a;
  logic           sign_b;
  logic [DSZ-1:0] mag_a;
  logic [DSZ-1:0] mag_b;
  logic [DSZ-1:0] div_quo;
  logic [DSZ-1:0] div_rem;
  logic           div_busy;
  logic           div_start;
  logic [DSZ-1:0] fixed;

  function automatic logic [DSZ-1:0] neg(input logic [DSZ-1:0] v);
    return (~v) + DSZ'(1);
  endfunction

  function automatic logic [DSZ-1:0] mag(input logic [DSZ-1:0] v);
    return v[DSZ-1] ? neg(v) : v;
  endfunction

  // Restarting the core from LOAD also flushes any iteration left by an abort
  assign div_start = (state == LOAD);

  div_int #(.DSZ(DSZ)) u_div (
    .clk       (clk),
    .rst       (div_start),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .busy      (div_busy),
    .zero      ()
  );

  always_comb begin
    fixed = '0;
    if (op_q == DIV_R) begin
      fixed = sign_a ? neg(div_rem) : div_rem;
    end else begin
      fixed = (sign_a ^ sign_b) ? neg(div_quo) : div_quo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      result <= '0;
      op_q   <= DIV_Q;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= div_op_e'(op);
            sign_a <= a[DSZ-1];
            sign_b <= b[DSZ-1];
            mag_a  <= mag(a);
            mag_b  <= mag(b);
            ready  <= 1'b0;
            busy   <= 1'b1;
            if (b == '0) begin
              state  <= DONE;
              done   <= 1'b1;
              dz     <= 1'b1;
              result <= '0;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (!div_busy) begin
            result <= fixed;
            dz     <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
